// File: rtl/pc_fetch_redirect_unit.sv
// pc_fetch_redirect_unit
//   Fetch-side owner of the architectural PC. Issues instruction reads with a
//   busywait handshake, hands PC / PC+step / instruction to the IF/ID boundary,
//   and services branch/jump redirects (flush wrong-path, drop in-flight read).
//
// Optional build macro: MISALIGN_CHECK_EN
//   defined   : misaligned redirect targets are rejected and reported on MISALIGNED
//   undefined : target[1:0] is cleared before loading the PC
//
// Ports
//   CLK, RESET                 clock, synchronous active-high reset
//   BRANCH_JUMP_MUX_SIGNAL     redirect request
//   BRANCH_JUMP_PC_IN[31:0]    redirect target
//   STALL                      hold IF/ID outputs
//   IMEM_BUSYWAIT              instruction memory not ready
//   IMEM_INSTRUCTION[31:0]     read data
//   IMEM_READ, IMEM_ADDRESS    read request / address
//   IF_PC, IF_PC_PLUS4         PC of delivered instruction and PC + PC_STEP
//   IF_INSTRUCTION, IF_VALID   delivered instruction and its valid flag
//   FLUSH                      one-cycle wrong-path pulse
//   MISALIGNED                 (MISALIGN_CHECK_EN only) rejected-redirect pulse
//
// State    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no read issued; first cycle after reset
// S_REQ    | read of pc_q outstanding / issued every cycle
// S_DRAIN  | redirect taken mid-read; waiting out the old read, data dropped
// S_HOLD   | read completed under STALL; instruction parked in skid buffer
module pc_fetch_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_JUMP_MUX_SIGNAL,
  input  logic [31:0] BRANCH_JUMP_PC_IN,
  input  logic        STALL,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_INSTRUCTION,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC_PLUS4,
  output logic [31:0] IF_INSTRUCTION,
  output logic        IF_VALID,
  output logic        FLUSH
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        MISALIGNED
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        flush_q, flush_d;
  // The skid buffer is occupied exactly while in S_HOLD, so no separate valid bit.
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic        redirect_ok;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_next_seq;

`ifdef MISALIGN_CHECK_EN
  logic        misaligned_q, misaligned_d;
  logic        misalign_hit;

  assign redirect_ok  = BRANCH_JUMP_MUX_SIGNAL && (BRANCH_JUMP_PC_IN[1:0] == 2'b00);
  assign misalign_hit = BRANCH_JUMP_MUX_SIGNAL && (BRANCH_JUMP_PC_IN[1:0] != 2'b00);
  assign redirect_tgt = BRANCH_JUMP_PC_IN;
`else
  assign redirect_ok  = BRANCH_JUMP_MUX_SIGNAL;
  assign redirect_tgt = BRANCH_JUMP_PC_IN & 32'hFFFF_FFFC;
`endif

  assign pc_next_seq = pc_q + PC_STEP;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_instr_d    = if_instr_q;
    if_valid_d    = if_valid_q;
    flush_d       = 1'b0;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
`ifdef MISALIGN_CHECK_EN
    misaligned_d  = misalign_hit;
`endif

    if (redirect_ok) begin
      // Redirect beats STALL and any completing read.
      pc_d         = redirect_tgt;
      flush_d      = 1'b1;
      if_valid_d   = 1'b0;
      skid_pc_d    = 32'h0;
      skid_instr_d = 32'h0;
      if (((state_q == S_REQ) || (state_q == S_DRAIN)) && IMEM_BUSYWAIT) begin
        state_d = S_DRAIN;
        // Re-redirect while draining keeps the original outstanding address.
        if (state_q == S_REQ) drain_addr_d = pc_q;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (!IMEM_BUSYWAIT) begin
            pc_d = pc_next_seq;
            if (!STALL) begin
              if_instr_d    = IMEM_INSTRUCTION;
              if_pc_d       = pc_q;
              if_pc_plus4_d = pc_next_seq;
              if_valid_d    = 1'b1;
            end else begin
              skid_instr_d = IMEM_INSTRUCTION;
              skid_pc_d    = pc_q;
              state_d      = S_HOLD;
            end
          end else if (!STALL) begin
            if_valid_d = 1'b0;
          end
        end
        S_DRAIN: begin
          if (!IMEM_BUSYWAIT) state_d = S_REQ;
        end
        S_HOLD: begin
          if (!STALL) begin
            if_instr_d    = skid_instr_q;
            if_pc_d       = skid_pc_q;
            if_pc_plus4_d = skid_pc_q + PC_STEP;
            if_valid_d    = 1'b1;
            state_d       = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VECTOR;
      drain_addr_q  <= RESET_VECTOR;
      if_pc_q       <= 32'h0;
      if_pc_plus4_q <= 32'h0;
      if_instr_q    <= 32'h0;
      if_valid_q    <= 1'b0;
      flush_q       <= 1'b0;
      skid_pc_q     <= 32'h0;
      skid_instr_q  <= 32'h0;
`ifdef MISALIGN_CHECK_EN
      misaligned_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
      flush_q       <= flush_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
`ifdef MISALIGN_CHECK_EN
      misaligned_q  <= misaligned_d;
`endif
    end
  end

  // Read request is a pure decode of the state register.
  assign IMEM_READ      = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign IMEM_ADDRESS   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign IF_PC          = if_pc_q;
  assign IF_PC_PLUS4    = if_pc_plus4_q;
  assign IF_INSTRUCTION = if_instr_q;
  assign IF_VALID       = if_valid_q;
  assign FLUSH          = flush_q;
`ifdef MISALIGN_CHECK_EN
  assign MISALIGNED     = misaligned_q;
`endif

endmodule

// File: tb/tb_pc_fetch_redirect_unit.sv
// Testbench for pc_fetch_redirect_unit.
// The bench plays instruction memory (data is a fixed hash of the address).
// The reference model works at the level of the delivered instruction stream:
// each instruction accepted by the consumer (IF_VALID && !STALL at an edge)
// must carry the next sequential PC, restarting at the target after a redirect
// and at the reset vector after reset, with instruction = hash(PC).
module tb_pc_fetch_redirect_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        BRANCH_JUMP_MUX_SIGNAL = 1'b0;
  logic [31:0] BRANCH_JUMP_PC_IN = 32'h0;
  logic        STALL = 1'b0;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] IMEM_INSTRUCTION = 32'h0;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] IF_PC;
  logic [31:0] IF_PC_PLUS4;
  logic [31:0] IF_INSTRUCTION;
  logic        IF_VALID;
  logic        FLUSH;
`ifdef MISALIGN_CHECK_EN
  logic        MISALIGNED;
`endif

  pc_fetch_redirect_unit #(.RESET_VECTOR(RV), .PC_STEP(32'd4)) dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .BRANCH_JUMP_MUX_SIGNAL (BRANCH_JUMP_MUX_SIGNAL),
    .BRANCH_JUMP_PC_IN      (BRANCH_JUMP_PC_IN),
    .STALL                  (STALL),
    .IMEM_BUSYWAIT          (IMEM_BUSYWAIT),
    .IMEM_INSTRUCTION       (IMEM_INSTRUCTION),
    .IMEM_READ              (IMEM_READ),
    .IMEM_ADDRESS           (IMEM_ADDRESS),
    .IF_PC                  (IF_PC),
    .IF_PC_PLUS4            (IF_PC_PLUS4),
    .IF_INSTRUCTION         (IF_INSTRUCTION),
    .IF_VALID               (IF_VALID),
    .FLUSH                  (FLUSH)
`ifdef MISALIGN_CHECK_EN
    ,
    .MISALIGNED             (MISALIGNED)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          rst;
    bit          redir;
    logic [31:0] tgt;
  } ev_t;

  ev_t ev_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  stim_done = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of stimulus; it takes effect at the following rising edge.
  task automatic step(input bit rst, input bit bw, input bit st, input bit rd,
                      input logic [31:0] tgt);
    @(posedge CLK);
    #2;
    RESET                  = rst;
    IMEM_BUSYWAIT          = bw;
    STALL                  = st;
    BRANCH_JUMP_MUX_SIGNAL = rd;
    BRANCH_JUMP_PC_IN      = tgt;
    IMEM_INSTRUCTION       = bw ? $urandom : mem_word(IMEM_ADDRESS);
    if (rst || rd) ev_q.push_back('{cyc, rst, rd, tgt});
  endtask

  task automatic clean(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Stimulus
  initial begin
    bit          rst, bw, st, rd;
    logic [31:0] tgt;
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    clean(3);                                  // 0x0, 0x4, 0x8 ...
    repeat (3) step(0, 1, 0, 0, 32'h0);        // wait states
    clean(2);
    step(0, 1, 0, 1, 32'h100);                 // redirect mid-read
    step(0, 1, 0, 0, 32'h0);
    clean(4);
    step(0, 0, 1, 0, 32'h0);                   // stall over a completion
    step(0, 1, 1, 0, 32'h0);
    clean(3);
    step(0, 0, 1, 1, 32'h40);                  // redirect + stall together
    clean(3);
    step(0, 0, 0, 1, 32'hFFFF_FFF8);           // wrap-around
    clean(4);
    step(0, 1, 0, 1, 32'h200);                 // enter DRAIN ...
    step(0, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);                   // ... and reset inside it
    clean(4);
    step(0, 0, 0, 1, 32'h102);                 // misaligned target
    clean(4);
    repeat (3000) begin
      rst = ($urandom_range(0, 999) < 5);
      bw  = ($urandom_range(0, 99) < 30);
      st  = ($urandom_range(0, 99) < 25);
      rd  = !rst && ($urandom_range(0, 99) < 6);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      step(rst, bw, st, rd, tgt);
    end
    clean(4);
    stim_done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    bit          prev_rst   = 1'b1;
    bit          prev_flush = 1'b0;
    bit          prev_mis   = 1'b0;
    bit          prev_pend  = 1'b0;
    logic [31:0] prev_addr  = 32'h0;
    logic [31:0] exp_pc     = RV;
    int          acc        = 0;
    int          idle_run   = 0;
    bit          cur_rst, cur_rd;
    logic [31:0] cur_tgt;
    ev_t         ev;

    while (!stim_done) begin
      @(negedge CLK);

      if (prev_rst) begin
        check("rst_imem_read", {31'h0, IMEM_READ}, 32'h0);
        check("rst_imem_addr", IMEM_ADDRESS, RV);
        check("rst_if_pc", IF_PC, 32'h0);
        check("rst_if_pc4", IF_PC_PLUS4, 32'h0);
        check("rst_if_instr", IF_INSTRUCTION, 32'h0);
        check("rst_if_valid", {31'h0, IF_VALID}, 32'h0);
        check("rst_flush", {31'h0, FLUSH}, 32'h0);
      end else begin
        check("flush", {31'h0, FLUSH}, {31'h0, prev_flush});
        if (prev_flush) check("valid_after_flush", {31'h0, IF_VALID}, 32'h0);
        if (prev_pend) begin
          check("read_held", {31'h0, IMEM_READ}, 32'h1);
          check("addr_held", IMEM_ADDRESS, prev_addr);
        end
`ifdef MISALIGN_CHECK_EN
        check("misaligned", {31'h0, MISALIGNED}, {31'h0, prev_mis});
`endif
      end

      cur_rst = 1'b0;
      cur_rd  = 1'b0;
      cur_tgt = 32'h0;
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) void'(ev_q.pop_front());
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        ev      = ev_q.pop_front();
        cur_rst = ev.rst;
        cur_rd  = ev.redir;
        cur_tgt = ev.tgt;
      end

      if (!cur_rst && !prev_rst && IF_VALID && !STALL) begin
        check("deliver_pc", IF_PC, exp_pc);
        check("deliver_pc4", IF_PC_PLUS4, exp_pc + 32'd4);
        check("deliver_instr", IF_INSTRUCTION, mem_word(exp_pc));
        exp_pc   = exp_pc + 32'd4;
        acc++;
        idle_run = 0;
      end else begin
        idle_run++;
        if (idle_run > 150) begin
          n_cmp++;
          n_err++;
          $display("FAIL progress: no delivery for %0d cycles, required <= 150 (cycle %0d)",
                   idle_run, cyc);
          idle_run = 0;
        end
      end

      prev_flush = 1'b0;
      prev_mis   = 1'b0;
      if (cur_rst) begin
        exp_pc = RV;
      end else if (cur_rd) begin
`ifdef MISALIGN_CHECK_EN
        if (cur_tgt[1:0] != 2'b00) begin
          prev_mis = 1'b1;
        end else begin
          exp_pc     = cur_tgt;
          prev_flush = 1'b1;
        end
`else
        exp_pc     = cur_tgt & 32'hFFFF_FFFC;
        prev_flush = 1'b1;
`endif
      end
      prev_rst  = cur_rst;
      prev_pend = IMEM_READ && IMEM_BUSYWAIT && !cur_rst;
      prev_addr = IMEM_ADDRESS;
    end

    check("enough_deliveries", {31'h0, (acc > 200)}, 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_redirect_unit.md
Name: pc_fetch_redirect_unit

Overview:
Fetch-side consumer of the branch/jump redirect interface. Owns the architectural PC, issues instruction reads to instruction memory using a busywait handshake, and presents PC, PC+4 and the instruction to the IF/ID boundary. On a redirect request it loads the target PC, flushes the wrong-path instruction, and discards any in-flight read.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
BRANCH_JUMP_MUX_SIGNAL  input  1  redirect request, sampled on CLK.
BRANCH_JUMP_PC_IN  input  32  redirect target; valid when the request is high.
STALL  input  1  hazard-unit hold of the IF/ID outputs.
IMEM_BUSYWAIT  input  1  instruction memory is not ready; the read is still pending.
IMEM_INSTRUCTION  input  32  read data; valid when IMEM_READ=1 and IMEM_BUSYWAIT=0.
IMEM_READ  output  1  read request.
IMEM_ADDRESS  output  32  read address.
IF_PC  output  32  PC of the delivered instruction.
IF_PC_PLUS4  output  32  IF_PC + PC_STEP.
IF_INSTRUCTION  output  32  delivered instruction.
IF_VALID  output  1  IF outputs hold a valid instruction.
FLUSH  output  1  one-cycle pulse; the IF/ID contents are wrong-path.

Behaviour:
- Reset (RESET high at the edge): PC=RESET_VECTOR; IMEM_READ=0; IMEM_ADDRESS=RESET_VECTOR; IF_PC, IF_PC_PLUS4 and IF_INSTRUCTION=0; IF_VALID=0; FLUSH=0; skid buffer empty; state=IDLE. Reset overrides every other input, including mid-read. Any pending read is abandoned.
- States: IDLE, REQ, DRAIN, HOLD.
- IDLE: IMEM_READ=0. Moves to REQ on the next edge.
- REQ: IMEM_READ=1, IMEM_ADDRESS=PC. A read completes on an edge where IMEM_BUSYWAIT=0.
  - Completion with STALL=0: IF_INSTRUCTION<=data, IF_PC<=PC, IF_PC_PLUS4<=PC+PC_STEP, IF_VALID<=1, PC<=PC+PC_STEP. Stays in REQ, giving back-to-back reads.
  - Completion with STALL=1: data and PC go into the skid buffer. IF outputs hold. PC<=PC+PC_STEP. Moves to HOLD.
  - No completion with STALL=0: IF_VALID<=0.
- HOLD: IMEM_READ=0. When STALL drops, the skid buffer moves to the IF outputs with IF_VALID=1, and the state returns to REQ.
- Redirect (BRANCH_JUMP_MUX_SIGNAL=1 at the edge) has priority over STALL and over completion:
  - PC<=target, FLUSH<=1 for exactly one cycle, IF_VALID<=0, skid buffer cleared.
  - From REQ with IMEM_BUSYWAIT=1: go to DRAIN. IMEM_READ stays high at the old address until completion, and the returned data is discarded. Then go to REQ at the target.
  - From REQ with IMEM_BUSYWAIT=0: the completing data is discarded. Next state is REQ at the target.
  - A redirect in DRAIN overwrites PC again. Only the latest target is fetched.
- Arithmetic is 32-bit wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No trap.
- Outputs are registered except IMEM_ADDRESS, which equals the PC register in REQ/IDLE and the latched old address in DRAIN.

Optional Feature:
MISALIGN_CHECK_EN.
- Defined: adds output MISALIGNED (1 bit, reset 0). A redirect with target[1:0]!=2'b00 is ignored: no PC load, no FLUSH. MISALIGNED pulses high for one cycle.
- Undefined: target[1:0] is forced to 2'b00 before loading the PC, and no extra port exists.

Test Plan:
1. Reset release, RESET_VECTOR=0, BUSYWAIT always 0 → IMEM_ADDRESS sequence 0x0, 0x4, 0x8. IF_PC follows one cycle later; IF_VALID=1 from the first completion.
2. BUSYWAIT high for 3 cycles on address 0x8 → IMEM_ADDRESS holds 0x8 and IF_VALID=0 during the wait. Delivery occurs on the first edge with BUSYWAIT=0, and the next address is 0xC.
3. Redirect to 0x100 while the read of 0x10 has BUSYWAIT=1 → FLUSH pulses once. The 0x10 data is never delivered (IF_VALID=0). The next IMEM_ADDRESS is 0x100, and IF_PC=0x100 on its delivery.
4. STALL high for 2 cycles while the read of 0x20 completes → IF outputs stay frozen on 0x1C. After STALL drops, IF_PC=0x20 with the correct instruction, and no instruction is lost or duplicated.
5. Redirect and STALL in the same cycle, target 0x40 → the redirect wins: FLUSH=1, skid buffer cleared, next fetch at 0x40.
6. RESET asserted mid-DRAIN → all outputs return to their reset values on the next edge, and fetch restarts at RESET_VECTOR. With MISALIGN_CHECK_EN, a redirect to 0x102 gives MISALIGNED=1, no FLUSH, and the PC unchanged.
